// File: rtl/maze_rng_lut.sv
// -----------------------------------------------------------------------------
// maze_rng_lut
//
// Support block for pellet/ghost placement in the maze game. It provides:
//   - an 8-bit maximal-length Fibonacci LFSR (x^8+x^6+x^5+x^4+1),
//   - the LFSR value reduced into maze column/row range,
//   - a zero-latency wall lookup for the 27x24 cell map (1 = wall, 0 = free).
// Placement FSMs keep stepping the LFSR and retry until the lookup reads free.
//
// Optional build macro: MAP_TUNNEL_EN
//   When defined, border cells (0,11) and (26,11) read as free, forming the
//   side wrap tunnel. Out-of-range cells still read as wall.
//
// Parameters:
//   SEED   LFSR reset value, must be nonzero (an all-zero LFSR locks up)
//   MAP_W  maze width in cells  (x range 0..MAP_W-1)
//   MAP_H  maze height in cells (y range 0..MAP_H-1)
//
// Ports:
//   clock   in   1  system clock, all state updates on rising edge
//   reset   in   1  synchronous, active-high; reloads SEED, wins over rng_en
//   rng_en  in   1  advance the LFSR one step on this edge
//   rand_q  out  8  current LFSR state
//   rand_x  out  8  rand_q % MAP_W, combinational
//   rand_y  out  7  rand_q % MAP_H, combinational
//   x       in   8  lookup column
//   y       in   7  lookup row
//   wall_q  out  1  combinational wall flag for cell (x,y)
// -----------------------------------------------------------------------------
module maze_rng_lut #(
  parameter logic [7:0] SEED  = 8'hA5,
  parameter int         MAP_W = 27,
  parameter int         MAP_H = 24
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rng_en,
  output logic [7:0] rand_q,
  output logic [7:0] rand_x,
  output logic [6:0] rand_y,
  input  logic [7:0] x,
  input  logic [6:0] y,
  output logic       wall_q
);

  // Ghost house footprint, centred in the 27x24 map.
  localparam int GH_X0 = 11;
  localparam int GH_X1 = 15;
  localparam int GH_Y0 = 10;
  localparam int GH_Y1 = 12;

  // Row carrying the side tunnel when MAP_TUNNEL_EN is defined.
  localparam int TUNNEL_Y = 11;

  // ---------------------------------------------------------------------------
  // LFSR
  // ---------------------------------------------------------------------------
  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;
  logic       fb;

  assign fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  always_comb begin
    lfsr_d = lfsr_q;
    if (rng_en) begin
      lfsr_d = {lfsr_q[6:0], fb};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign rand_q = lfsr_q;

  // Constant-divisor remainders; MAP_W/MAP_H fit in 8 bits, and the results
  // are bounded by the divisor so the narrowing to the port widths is lossless.
  assign rand_x = lfsr_q % 8'(MAP_W);
  assign rand_y = 7'(lfsr_q % 8'(MAP_H));

  // ---------------------------------------------------------------------------
  // Wall lookup
  // ---------------------------------------------------------------------------
  logic x_oob;
  logic y_oob;
  logic on_border;
  logic in_ghost_house;
  logic on_pillar;
  logic wall_d;

  assign x_oob = (x >= 8'(MAP_W));
  assign y_oob = (y >= 7'(MAP_H));

  assign on_border = (x == 8'd0) || (x == 8'(MAP_W - 1)) ||
                     (y == 7'd0) || (y == 7'(MAP_H - 1));

  assign in_ghost_house = (x >= 8'(GH_X0)) && (x <= 8'(GH_X1)) &&
                          (y >= 7'(GH_Y0)) && (y <= 7'(GH_Y1));

  // x%4==3 and y%4==3 reduce to the two low bits being set.
  assign on_pillar = (x[1:0] == 2'b11) && (y[1:0] == 2'b11);

`ifdef MAP_TUNNEL_EN
  logic is_tunnel;
  assign is_tunnel = ((x == 8'd0) || (x == 8'(MAP_W - 1))) &&
                     (y == 7'(TUNNEL_Y));
`endif

  // Priority order matters: out-of-range first, then the tunnel openings
  // punch through the border, then the interior features.
  always_comb begin
    wall_d = 1'b0;
    if (x_oob || y_oob) begin
      wall_d = 1'b1;
`ifdef MAP_TUNNEL_EN
    end else if (is_tunnel) begin
      wall_d = 1'b0;
`endif
    end else if (on_border) begin
      wall_d = 1'b1;
    end else if (in_ghost_house) begin
      wall_d = 1'b1;
    end else if (on_pillar) begin
      wall_d = 1'b1;
    end
  end

  assign wall_q = wall_d;

endmodule

// File: tb/tb_maze_rng_lut.sv
module tb_maze_rng_lut;

  logic       clk;
  logic       reset;
  logic       rng_en;
  logic [7:0] rand_q;
  logic [7:0] rand_x;
  logic [6:0] rand_y;
  logic [7:0] x;
  logic [6:0] y;
  logic       wall_q;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] model_q;

  maze_rng_lut dut (
    .clock  (clk),
    .reset  (reset),
    .rng_en (rng_en),
    .rand_q (rand_q),
    .rand_x (rand_x),
    .rand_y (rand_y),
    .x      (x),
    .y      (y),
    .wall_q (wall_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    logic b;
    b = s[7] ^ s[5] ^ s[4] ^ s[3];
    return {s[6:0], b};
  endfunction

  function automatic logic wall_model(input int xi, input int yi);
    if (xi >= 27 || yi >= 24) return 1'b1;
`ifdef MAP_TUNNEL_EN
    if ((xi == 0 || xi == 26) && yi == 11) return 1'b0;
`endif
    if (xi == 0 || xi == 26 || yi == 0 || yi == 23) return 1'b1;
    if (xi >= 11 && xi <= 15 && yi >= 10 && yi <= 12) return 1'b1;
    if ((xi % 4) == 3 && (yi % 4) == 3) return 1'b1;
    return 1'b0;
  endfunction

  // One clock edge; the expected value is queued before the edge and popped
  // and compared 1 time unit after it.
  task automatic cycle_and_check(input string name);
    logic [7:0] e;
    logic [7:0] ex;
    logic [6:0] ey;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty", name);
      return;
    end
    e  = exp_q.pop_front();
    ex = 8'(int'(e) % 27);
    ey = 7'(int'(e) % 24);
    checks++;
    if (rand_q !== e) begin
      errors++;
      $display("FAIL %s rand_q got %02h expected %02h", name, rand_q, e);
    end
    checks++;
    if (rand_x !== ex) begin
      errors++;
      $display("FAIL %s rand_x got %0d expected %0d (rand_q exp %02h)", name, rand_x, ex, e);
    end
    checks++;
    if (rand_y !== ey) begin
      errors++;
      $display("FAIL %s rand_y got %0d expected %0d (rand_q exp %02h)", name, rand_y, ey, e);
    end
  endtask

  task automatic drive_cycle(input logic rst, input logic en, input string name);
    @(negedge clk);
    reset  = rst;
    rng_en = en;
    if (rst) model_q = 8'hA5;
    else if (en) model_q = lfsr_next(model_q);
    exp_q.push_back(model_q);
    cycle_and_check(name);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, "reset");
    // Spec-literal values for the seed state.
    checks++;
    if (rand_q !== 8'hA5 || rand_x !== 8'd3 || rand_y !== 7'd21) begin
      errors++;
      $display("FAIL reset_seed got %02h/%0d/%0d expected a5/3/21", rand_q, rand_x, rand_y);
    end
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, "hold");
  endtask

  task automatic test_first_steps;
    logic [7:0] lit[3];
    lit[0] = 8'h4A; lit[1] = 8'h95; lit[2] = 8'h2A;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b1, "step");
      checks++;
      if (rand_q !== lit[i]) begin
        errors++;
        $display("FAIL step_literal%0d got %02h expected %02h", i, rand_q, lit[i]);
      end
    end
    checks++;
    if (rand_x !== 8'd20 - 8'd20 + 8'(8'h2A % 27) || rand_y !== 7'(8'h2A % 24)) begin
      errors++;
      $display("FAIL step_xy got %0d/%0d expected 15/18", rand_x, rand_y);
    end
  endtask

  task automatic test_period;
    logic seen_zero;
    int   first_seed;
    drive_cycle(1'b1, 1'b0, "period_reset");
    seen_zero  = 1'b0;
    first_seed = -1;
    for (int i = 1; i <= 255; i++) begin
      drive_cycle(1'b0, 1'b1, "period");
      if (rand_q === 8'h00) seen_zero = 1'b1;
      if (rand_q === 8'hA5 && first_seed < 0) first_seed = i;
    end
    checks++;
    if (first_seed != 255) begin
      errors++;
      $display("FAIL period first return to a5 at step %0d expected 255", first_seed);
    end
    checks++;
    if (seen_zero) begin
      errors++;
      $display("FAIL period zero_state seen 1 expected 0");
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 10; i++) drive_cycle(1'b0, 1'b1, "pre_mid");
    drive_cycle(1'b1, 1'b1, "reset_mid");
    checks++;
    if (rand_q !== 8'hA5) begin
      errors++;
      $display("FAIL reset_mid got %02h expected a5", rand_q);
    end
    drive_cycle(1'b0, 1'b1, "post_mid");
    checks++;
    if (rand_q !== 8'h4A) begin
      errors++;
      $display("FAIL post_mid got %02h expected 4a", rand_q);
    end
  endtask

  task automatic test_lookup_points;
    int  px[11] = '{0, 26, 5, 3, 13, 14, 3, 1, 27, 5, 255};
    int  py[11] = '{5, 0, 23, 3, 11, 18, 21, 1, 5, 24, 127};
    logic pe[11] = '{1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1};
    for (int i = 0; i < 11; i++) begin
      x = 8'(px[i]);
      y = 7'(py[i]);
      #1;
      checks++;
      if (wall_q !== pe[i]) begin
        errors++;
        $display("FAIL lookup (%0d,%0d) got %b expected %b", px[i], py[i], wall_q, pe[i]);
      end
    end
  endtask

  task automatic test_tunnel;
    logic tun;
`ifdef MAP_TUNNEL_EN
    tun = 1'b0;
`else
    tun = 1'b1;
`endif
    x = 8'd0;  y = 7'd11; #1;
    checks++;
    if (wall_q !== tun) begin
      errors++;
      $display("FAIL tunnel_left got %b expected %b", wall_q, tun);
    end
    x = 8'd26; y = 7'd11; #1;
    checks++;
    if (wall_q !== tun) begin
      errors++;
      $display("FAIL tunnel_right got %b expected %b", wall_q, tun);
    end
    x = 8'd0;  y = 7'd10; #1;
    checks++;
    if (wall_q !== 1'b1) begin
      errors++;
      $display("FAIL tunnel_neighbor got %b expected 1", wall_q);
    end
  endtask

  task automatic test_exhaustive;
    logic e;
    for (int xi = 0; xi < 256; xi++) begin
      for (int yi = 0; yi < 128; yi++) begin
        x = 8'(xi);
        y = 7'(yi);
        #1;
        e = wall_model(xi, yi);
        checks++;
        if (wall_q !== e) begin
          errors++;
          $display("FAIL sweep (%0d,%0d) got %b expected %b", xi, yi, wall_q, e);
        end
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    rng_en  = 1'b0;
    x       = 8'd0;
    y       = 7'd0;
    model_q = 8'hA5;
    test_reset();
    test_first_steps();
    test_period();
    test_reset_mid();
    test_lookup_points();
    test_tunnel();
    test_exhaustive();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover %0d entries expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
